// File: rtl/bomberman_pkg.sv
// Shared player/map definitions: key command codes, tile geometry, map size,
// sequencer state encoding and the one-tile step helper.
package bomberman_pkg;

  typedef enum logic [2:0] {
    CMD_UP    = 3'd0,
    CMD_DOWN  = 3'd1,
    CMD_LEFT  = 3'd2,
    CMD_RIGHT = 3'd3,
    CMD_BOMB  = 3'd4,
    CMD_NOOP  = 3'd5
  } cmd_e;

  localparam int TILE_W   = 64;
  localparam int TILE_H   = 48;
  localparam int MAP_COLS = 640 / TILE_W;
  localparam int MAP_ROWS = 480 / TILE_H;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_QUERY = 2'd1,
    ST_MOVE  = 2'd2
  } seq_state_e;

  typedef struct packed {
    logic       ok;
    logic [3:0] x;
    logic [3:0] y;
  } tile_step_t;

  // One extra bit keeps 0-1 and 15+1 out of range instead of wrapping back in.
  function automatic tile_step_t step_tile(input logic [3:0] x, input logic [3:0] y,
                                           input logic [1:0] dir,
                                           input logic [4:0] cols, input logic [4:0] rows);
    logic [4:0] nx;
    logic [4:0] ny;
    tile_step_t r;
    nx = {1'b0, x};
    ny = {1'b0, y};
    case (dir)
      2'd0:    ny = ny - 5'd1;
      2'd1:    ny = ny + 5'd1;
      2'd2:    nx = nx - 5'd1;
      default: nx = nx + 5'd1;
    endcase
    r.ok = (nx < cols) && (ny < rows);
    r.x  = nx[3:0];
    r.y  = ny[3:0];
    return r;
  endfunction

endpackage

// File: rtl/move_sequencer.sv
// Turns key commands into map-checked one-tile moves of STEPS frames each; query issued the cycle after a key.
// Grant wait is unbounded; keys arriving while busy collapse into a single last-wins pending direction.
module move_sequencer #(
  parameter int STEPS    = 8,
  parameter int MAP_COLS = bomberman_pkg::MAP_COLS,
  parameter int MAP_ROWS = bomberman_pkg::MAP_ROWS
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [2:0] key_cmd,
  input  logic       key_valid,
  input  logic [3:0] tile_x,
  input  logic [3:0] tile_y,
  output logic       map_req,
  output logic [3:0] map_x,
  output logic [3:0] map_y,
  input  logic       map_gnt,
  input  logic       map_free,
  output logic [2:0] command,
  output logic       enabled,
  output logic [4:0] xSpeed,
  output logic [4:0] ySpeed,
  output logic       bomb_req,
  output logic       blocked,
  output logic       busy
);
  import bomberman_pkg::*;

  localparam int         CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [4:0] COLS5 = 5'(MAP_COLS);
  localparam logic [4:0] ROWS5 = 5'(MAP_ROWS);

  seq_state_e       state, state_nxt;
  logic [3:0]       tgt_x, tgt_y, tgt_x_nxt, tgt_y_nxt;
  logic [1:0]       dir_q, dir_nxt, pend_dir, chain_dir;
  logic             pend_vld;
  logic [CNT_W-1:0] cnt;
  logic             ld_tgt, blk_set, bomb_set;
  logic             key_dir, key_bomb, move_done;
  tile_step_t       idle_step, chain_step;

  assign key_dir    = key_valid && !key_cmd[2];
  assign key_bomb   = key_valid && (key_cmd == CMD_BOMB);
  assign move_done  = (state == ST_MOVE) && (cnt == '0);
  // A key landing on the final MOVE cycle is newer than anything already pending.
  assign chain_dir  = key_dir ? key_cmd[1:0] : pend_dir;
  assign idle_step  = step_tile(tile_x, tile_y, key_cmd[1:0], COLS5, ROWS5);
  assign chain_step = step_tile(tgt_x, tgt_y, chain_dir, COLS5, ROWS5);

  always_ff @(posedge frame_clk) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ld_tgt    = 1'b0;
    tgt_x_nxt = tgt_x;
    tgt_y_nxt = tgt_y;
    dir_nxt   = dir_q;
    blk_set   = 1'b0;
    bomb_set  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (key_dir) begin
          if (idle_step.ok) begin
            ld_tgt    = 1'b1;
            tgt_x_nxt = idle_step.x;
            tgt_y_nxt = idle_step.y;
            dir_nxt   = key_cmd[1:0];
            state_nxt = ST_QUERY;
          end else begin
            blk_set = 1'b1;
          end
        end else if (key_bomb) begin
          bomb_set = 1'b1;
        end
      end
      ST_QUERY: begin
        if (map_gnt) begin
          if (map_free) begin
            state_nxt = ST_MOVE;
          end else begin
            blk_set   = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_MOVE: begin
        if (move_done) begin
          if (key_dir || pend_vld) begin
            if (chain_step.ok) begin
              ld_tgt    = 1'b1;
              tgt_x_nxt = chain_step.x;
              tgt_y_nxt = chain_step.y;
              dir_nxt   = chain_dir;
              state_nxt = ST_QUERY;
            end else begin
              blk_set   = 1'b1;
              state_nxt = ST_IDLE;
            end
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      tgt_x    <= '0;
      tgt_y    <= '0;
      dir_q    <= '0;
      cnt      <= '0;
      pend_vld <= 1'b0;
      pend_dir <= '0;
      bomb_req <= 1'b0;
      blocked  <= 1'b0;
    end else begin
      bomb_req <= bomb_set;
      blocked  <= blk_set;
      if (ld_tgt) begin
        tgt_x <= tgt_x_nxt;
        tgt_y <= tgt_y_nxt;
        dir_q <= dir_nxt;
      end
      if (state == ST_QUERY && state_nxt == ST_MOVE) cnt <= CNT_W'(STEPS - 1);
      else if (state == ST_MOVE && cnt != '0)        cnt <= cnt - 1'b1;
      // Pending is consumed at MOVE end and never survives a return to IDLE.
      if (state_nxt == ST_IDLE || move_done) begin
        pend_vld <= 1'b0;
      end else if (state != ST_IDLE && key_dir) begin
        pend_vld <= 1'b1;
        pend_dir <= key_cmd[1:0];
      end
    end
  end

  always_comb begin
    map_req = 1'b0;
    map_x   = '0;
    map_y   = '0;
    enabled = 1'b0;
    command = CMD_NOOP;
    busy    = (state != ST_IDLE);
    if (state == ST_QUERY) begin
      map_req = 1'b1;
      map_x   = tgt_x;
      map_y   = tgt_y;
    end
    if (state == ST_MOVE) begin
      enabled = 1'b1;
      command = {1'b0, dir_q};
    end
  end

  assign xSpeed = 5'(TILE_W / STEPS);
  assign ySpeed = 5'(TILE_H / STEPS);

endmodule
